karatsuba_seq_ctrl: RTL

- Sequential 8x8 unsigned Karatsuba multiplier controller.
- Time-shares one 10-bit-address multiplier ROM across the three Karatsuba partial products, in order A = Xl*Yl, B = Xh*Yh, C = (Xl+Xh)*(Yl+Yh).
- Recombines the partials into a registered 16-bit product.
- Sits between the operand source and the shared ROM. It replaces three parallel ROM instances with one port plus this FSM.

---
 rtl/karatsuba_seq_ctrl.sv | 138 +++++++++++++
 1 files changed

// File: rtl/karatsuba_seq_ctrl.sv
`default_nettype none
// ============================================================================
// karatsuba_seq_ctrl : 8x8 unsigned Karatsuba multiplier sharing one 5x5 ROM
// Revision: 1.0
// ============================================================================
module karatsuba_seq_ctrl #(
    parameter int ROM_LAT = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [7:0]  X,
    input  logic [7:0]  Y,
    output logic [9:0]  rom_addr,
    input  logic [9:0]  rom_data,
    output logic        busy,
    output logic        done,
    output logic [15:0] P
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOOK_A  = 3'd1,
        LOOK_B  = 3'd2,
        LOOK_C  = 3'd3,
        COMBINE = 3'd4
    } state_t;

    state_t      state_q, state_d;
    logic        wait_q,  wait_d;
    logic [7:0]  xr_q,    xr_d;
    logic [7:0]  yr_q,    yr_d;
    logic [9:0]  a_q,     a_d;
    logic [9:0]  b_q,     b_d;
    logic [9:0]  c_q,     c_d;
    logic [15:0] p_q,     p_d;
    logic        done_q,  done_d;

    logic        last;
    logic [4:0]  xs;
    logic [4:0]  ys;
    logic [9:0]  m;

    // ROM data is stable on the final cycle of each lookup state
    assign last = (wait_q == 1'(ROM_LAT));
    assign xs   = {1'b0, xr_q[3:0]} + {1'b0, xr_q[7:4]};
    assign ys   = {1'b0, yr_q[3:0]} + {1'b0, yr_q[7:4]};
    assign m    = c_q - a_q - b_q;

    always_comb begin
        state_d  = state_q;
        wait_d   = wait_q;
        xr_d     = xr_q;
        yr_d     = yr_q;
        a_d      = a_q;
        b_d      = b_q;
        c_d      = c_q;
        p_d      = p_q;
        done_d   = 1'b0;
        rom_addr = 10'd0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    xr_d    = X;
                    yr_d    = Y;
                    wait_d  = 1'b0;
                    state_d = LOOK_A;
                end
            end
            LOOK_A: begin
                rom_addr = {1'b0, xr_q[3:0], 1'b0, yr_q[3:0]};
                if (last) begin
                    a_d     = rom_data;
                    wait_d  = 1'b0;
                    state_d = LOOK_B;
                end else begin
                    wait_d  = 1'b1;
                end
            end
            LOOK_B: begin
                rom_addr = {1'b0, xr_q[7:4], 1'b0, yr_q[7:4]};
                if (last) begin
                    b_d     = rom_data;
                    wait_d  = 1'b0;
                    state_d = LOOK_C;
                end else begin
                    wait_d  = 1'b1;
                end
            end
            LOOK_C: begin
                rom_addr = {xs, ys};
                if (last) begin
                    c_d     = rom_data;
                    wait_d  = 1'b0;
                    state_d = COMBINE;
                end else begin
                    wait_d  = 1'b1;
                end
            end
            COMBINE: begin
                p_d     = (16'(b_q) << 8) + (16'(m) << 4) + 16'(a_q);
                done_d  = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            wait_q  <= 1'b0;
            xr_q    <= 8'd0;
            yr_q    <= 8'd0;
            a_q     <= 10'd0;
            b_q     <= 10'd0;
            c_q     <= 10'd0;
            p_q     <= 16'd0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
            xr_q    <= xr_d;
            yr_q    <= yr_d;
            a_q     <= a_d;
            b_q     <= b_d;
            c_q     <= c_d;
            p_q     <= p_d;
            done_q  <= done_d;
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign P    = p_q;

endmodule
`default_nettype wire
